// File: rtl/sisc_ctrl_mc_if.sv
// Control-unit bus: IR fields, status and memory handshake in, datapath controls out.
// master = control unit, slave = datapath side.
interface sisc_ctrl_mc_if #(
  parameter int OP_W     = 4,
  parameter int MM_W     = 4,
  parameter int STAT_W   = 4,
  parameter int ALU_OP_W = 5
);
  logic [OP_W-1:0]     opcode;
  logic [MM_W-1:0]     mm;
  logic [STAT_W-1:0]   stat;
  logic                mem_ready;
  logic                ir_load;
  logic                pc_write;
  logic [1:0]          pc_sel;
  logic                rf_we;
  logic                wb_sel;
  logic                stat_en;
  logic [ALU_OP_W-1:0] alu_op;
  logic                mem_rd;
  logic                mem_wr;
  logic                illegal;
  logic                halted;
  logic                mem_err;

  modport master (
    input  opcode, mm, stat, mem_ready,
    output ir_load, pc_write, pc_sel, rf_we, wb_sel, stat_en, alu_op,
           mem_rd, mem_wr, illegal, halted, mem_err
  );

  modport slave (
    output opcode, mm, stat, mem_ready,
    input  ir_load, pc_write, pc_sel, rf_we, wb_sel, stat_en, alu_op,
           mem_rd, mem_wr, illegal, halted, mem_err
  );
endinterface

// File: rtl/sisc_ctrl_mc.sv
// Multi-cycle SISC control unit: fetch/decode/execute/mem/writeback sequencing with
// flag-conditional branches, ready-handshake memory phase with timeout, and halt.
module sisc_ctrl_mc #(
  parameter int OP_W        = 4,
  parameter int MM_W        = 4,
  parameter int STAT_W      = 4,
  parameter int ALU_OP_W    = 5,
  parameter int MEM_TIMEOUT = 16
) (
  input logic            clk,
  input logic            rst_f,
  sisc_ctrl_mc_if.master bus
);
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [OP_W-1:0] OP_ALUR = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ALUI = OP_W'(2);
  localparam logic [OP_W-1:0] OP_LOD  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_STR  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_BRA  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_BRR  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_HLT  = '1;

  typedef enum logic [2:0] {
    S_START0    = 3'd0,
    S_START1    = 3'd1,
    S_FETCH     = 3'd2,
    S_DECODE    = 3'd3,
    S_EXECUTE   = 3'd4,
    S_MEM       = 3'd5,
    S_WRITEBACK = 3'd6,
    S_HALT      = 3'd7
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

  logic                is_alu_s, is_lod_s, is_str_s, is_mem_s, is_br_s, is_hlt_s;
  logic                illegal_s, taken_s;
  logic [ALU_OP_W-2:0] mm_ext_s;
  logic [ALU_OP_W-1:0] alu_val_s;

  // Opcode decode, branch condition and ALU operation value
  always_comb begin
    is_alu_s  = (bus.opcode == OP_ALUR) || (bus.opcode == OP_ALUI);
    is_lod_s  = (bus.opcode == OP_LOD);
    is_str_s  = (bus.opcode == OP_STR);
    is_mem_s  = is_lod_s || is_str_s;
    is_br_s   = (bus.opcode == OP_BRA) || (bus.opcode == OP_BRR);
    is_hlt_s  = (bus.opcode == OP_HLT);
    illegal_s = (bus.opcode > OP_BRR) && !is_hlt_s;
    taken_s   = (bus.mm == '0) || ((bus.stat & bus.mm[STAT_W-1:0]) != '0);
    mm_ext_s  = '0;
    mm_ext_s[MM_W-1:0] = bus.mm;
    if (is_mem_s) begin
      alu_val_s = {1'b1, {(ALU_OP_W-1){1'b0}}};
    end else begin
      alu_val_s = {(bus.opcode == OP_ALUI), mm_ext_s};
    end
  end

  // State, timeout counter and sticky error registers
  always_ff @(posedge clk) begin
    if (!rst_f) begin
      state_q <= S_START0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; the counter is zeroed in EXECUTE so every MEM visit starts fresh
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_START0: state_d = S_START1;
      S_START1: state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXECUTE;
      S_EXECUTE: begin
        cnt_d = '0;
        if (is_alu_s) begin
          state_d = S_WRITEBACK;
        end else if (is_mem_s) begin
          state_d = S_MEM;
        end else if (is_hlt_s) begin
          state_d = S_HALT;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        // ready wins over a timeout reached in the same cycle
        if (bus.mem_ready) begin
          state_d = is_lod_s ? S_WRITEBACK : S_FETCH;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WRITEBACK: state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_START0;
    endcase
  end

  // Control outputs from current state and IR fields
  always_comb begin
    bus.ir_load  = 1'b0;
    bus.pc_write = 1'b0;
    bus.pc_sel   = 2'b00;
    bus.rf_we    = 1'b0;
    bus.wb_sel   = 1'b0;
    bus.stat_en  = 1'b0;
    bus.alu_op   = '0;
    bus.mem_rd   = 1'b0;
    bus.mem_wr   = 1'b0;
    bus.illegal  = 1'b0;
    bus.halted   = 1'b0;
    bus.mem_err  = err_q;
    case (state_q)
      S_FETCH: begin
        bus.ir_load  = 1'b1;
        bus.pc_write = 1'b1;
        bus.pc_sel   = 2'b00;
      end
      S_DECODE: bus.illegal = illegal_s;
      S_EXECUTE: begin
        if (is_alu_s) begin
          bus.alu_op  = alu_val_s;
          bus.stat_en = 1'b1;
        end else if (is_mem_s) begin
          bus.alu_op = alu_val_s;
        end else if (is_br_s && taken_s) begin
          bus.pc_write = 1'b1;
          bus.pc_sel   = (bus.opcode == OP_BRA) ? 2'b01 : 2'b10;
        end else begin
          bus.alu_op = '0;
        end
      end
      S_MEM: begin
        bus.alu_op = alu_val_s;
        bus.mem_rd = is_lod_s;
        bus.mem_wr = is_str_s;
      end
      S_WRITEBACK: begin
        bus.rf_we  = 1'b1;
        bus.wb_sel = is_lod_s;
        bus.alu_op = alu_val_s;
      end
      S_HALT:  bus.halted = 1'b1;
      default: bus.halted = 1'b0;
    endcase
  end
endmodule

// File: tb/tb_sisc_ctrl_mc.sv
// Randomized instruction-level bench for sisc_ctrl_mc: each instruction is expanded
// into its expected per-cycle control vectors and compared cycle by cycle.
module tb_sisc_ctrl_mc;
  localparam int TMO = 16;

  typedef struct packed {
    logic       ir_load;
    logic       pc_write;
    logic [1:0] pc_sel;
    logic       rf_we;
    logic       wb_sel;
    logic       stat_en;
    logic [4:0] alu_op;
    logic       mem_rd;
    logic       mem_wr;
    logic       illegal;
    logic       halted;
    logic       mem_err;
  } outs_t;

  logic clk = 1'b0;
  logic rst_f;

  sisc_ctrl_mc_if #(.OP_W(4), .MM_W(4), .STAT_W(4), .ALU_OP_W(5)) bus ();

  sisc_ctrl_mc #(
    .OP_W(4), .MM_W(4), .STAT_W(4), .ALU_OP_W(5), .MEM_TIMEOUT(TMO)
  ) dut (
    .clk   (clk),
    .rst_f (rst_f),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit err_m = 1'b0;

  task automatic check_vec(input string tag, input outs_t obs, input outs_t exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic outs_t sample();
    outs_t o;
    o.ir_load  = bus.ir_load;
    o.pc_write = bus.pc_write;
    o.pc_sel   = bus.pc_sel;
    o.rf_we    = bus.rf_we;
    o.wb_sel   = bus.wb_sel;
    o.stat_en  = bus.stat_en;
    o.alu_op   = bus.alu_op;
    o.mem_rd   = bus.mem_rd;
    o.mem_wr   = bus.mem_wr;
    o.illegal  = bus.illegal;
    o.halted   = bus.halted;
    o.mem_err  = bus.mem_err;
    return o;
  endfunction

  function automatic outs_t idle();
    outs_t o;
    o = '0;
    o.mem_err = err_m;
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input string tag, input outs_t exp);
    #1;
    check_vec(tag, sample(), exp);
  endtask

  // Leaves the bench positioned in the first FETCH cycle after reset
  task automatic do_reset();
    outs_t e;
    rst_f = 1'b0;
    bus.mem_ready = 1'b0;
    tick();
    err_m = 1'b0;
    e = idle();
    expect_now("start0", e);
    rst_f = 1'b1;
    tick();
    expect_now("start1", e);
    tick();
  endtask

  task automatic halt_phase();
    outs_t e;
    for (int i = 0; i < 3; i++) begin
      bus.opcode    = 4'($urandom);
      bus.mm        = 4'($urandom);
      bus.stat      = 4'($urandom);
      bus.mem_ready = 1'($urandom);
      e = idle();
      e.halted = 1'b1;
      expect_now("halt", e);
      tick();
    end
    do_reset();
  endtask

  // ready_at: MEM cycle on which mem_ready is raised (0 = never)
  // abort_at: MEM cycle on which rst_f is pulled low (0 = never)
  task automatic run_instr(input logic [3:0] op, input logic [3:0] m, input logic [3:0] s,
                           input int ready_at, input int abort_at);
    outs_t e;
    outs_t o;
    bit    taken;
    bit    done;
    bus.opcode    = op;
    bus.mm        = m;
    bus.stat      = s;
    bus.mem_ready = 1'b0;
    e = idle();
    e.ir_load  = 1'b1;
    e.pc_write = 1'b1;
    expect_now("fetch", e);
    tick();
    e = idle();
    e.illegal = (op > 4'd6) && (op != 4'd15);
    expect_now("decode", e);
    tick();
    e = idle();
    if (op == 4'd1 || op == 4'd2) begin
      e.alu_op  = {(op == 4'd2), m};
      e.stat_en = 1'b1;
      expect_now("exec_alu", e);
      tick();
      e.stat_en = 1'b0;
      e.rf_we   = 1'b1;
      expect_now("wb_alu", e);
      tick();
    end else if (op == 4'd3 || op == 4'd4) begin
      e.alu_op = 5'b10000;
      expect_now("exec_mem", e);
      tick();
      done = 1'b0;
      for (int k = 1; k <= TMO && !done; k++) begin
        e = idle();
        e.alu_op = 5'b10000;
        e.mem_rd = (op == 4'd3);
        e.mem_wr = (op == 4'd4);
        if (k == abort_at) begin
          expect_now("mem_abort", e);
          do_reset();
          return;
        end
        bus.mem_ready = (k == ready_at);
        expect_now("mem", e);
        tick();
        bus.mem_ready = 1'b0;
        done = (k == ready_at);
      end
      if (!done) begin
        err_m = 1'b1;
        halt_phase();
      end else if (op == 4'd3) begin
        e = idle();
        e.rf_we  = 1'b1;
        e.wb_sel = 1'b1;
        #1;
        o = sample();
        o.alu_op = 5'b00000;
        check_vec("wb_lod", o, e);
        tick();
      end
    end else if (op == 4'd5 || op == 4'd6) begin
      taken = (m == 4'd0) || ((s & m) != 4'd0);
      if (taken) begin
        e.pc_write = 1'b1;
        e.pc_sel   = (op == 4'd5) ? 2'b01 : 2'b10;
      end
      expect_now("exec_br", e);
      tick();
    end else if (op == 4'd15) begin
      expect_now("exec_hlt", e);
      tick();
      halt_phase();
    end else begin
      expect_now("exec_nop", e);
      tick();
    end
  endtask

  initial begin
    logic [3:0] op, m, s;
    int r, ready_at, abort_at;
    rst_f         = 1'b0;
    bus.opcode    = 4'd0;
    bus.mm        = 4'd0;
    bus.stat      = 4'd0;
    bus.mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    do_reset();

    // directed cases
    run_instr(4'd0, 4'd0, 4'd0, 0, 0);
    run_instr(4'd0, 4'd0, 4'd0, 0, 0);
    run_instr(4'd0, 4'd0, 4'd0, 0, 0);
    run_instr(4'd1, 4'h3, 4'd0, 0, 0);
    run_instr(4'd2, 4'h3, 4'd0, 0, 0);
    run_instr(4'd5, 4'b0010, 4'b0010, 0, 0);
    run_instr(4'd5, 4'b0010, 4'b0001, 0, 0);
    run_instr(4'd6, 4'b0000, 4'b0000, 0, 0);
    run_instr(4'd3, 4'd0, 4'd0, 3, 0);
    run_instr(4'd4, 4'd0, 4'd0, 1, 0);
    run_instr(4'd3, 4'd0, 4'd0, 0, 0);
    run_instr(4'd3, 4'd0, 4'd0, TMO, 0);
    run_instr(4'hA, 4'd5, 4'd5, 0, 0);
    run_instr(4'hF, 4'd0, 4'd0, 0, 0);
    run_instr(4'd3, 4'd0, 4'd0, 0, 2);
    run_instr(4'd4, 4'd0, 4'd0, 0, TMO);

    // randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      op = 4'($urandom_range(0, 15));
      m  = 4'($urandom);
      s  = 4'($urandom);
      if ($urandom_range(0, 3) == 0) m = 4'd0;
      r = $urandom_range(0, 9);
      ready_at = (r == 0) ? 0 : ((r == 1) ? TMO : $urandom_range(1, 4));
      abort_at = ($urandom_range(0, 19) == 0) ? $urandom_range(1, 3) : 0;
      run_instr(op, m, s, ready_at, abort_at);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
